pl_tx_stream_arbiter: RTL and testbench
=======================================

// Module: pl_tx_stream_arbiter
// PURPOSE
//  Schedules the physical-layer TX stream among three sources:
//   - LTSSM ordered sets
//   - periodic SKP ordered-set insertion
//   - data-link TLP/DLLP traffic (filler idles otherwise)
//  Drives per-source grants and the TX mux select ahead of the framing/scrambler path.
//  Guarantees packets are never split, while SKP spacing is tracked and bounded.
// PARAMETERS
//  SKP_INTERVAL   'd370  cycles between SKP insertions (counter threshold)
//  SKP_MAX_DEFER  'd128  extra cycles SKP may wait behind a packet before overdue
//  CNT_WIDTH      'd10   SKP counter width; must hold SKP_INTERVAL+SKP_MAX_DEFER
// PORTS
//  clk          in   1          single clock, all logic on rising edge
//  rst          in   1          synchronous, active-high reset
//  link_up      in   1          LTSSM L0 indication; gates data traffic
//  os_req       in   1          LTSSM requests to send an ordered set
//  os_last      in   1          current OS beat is the last one
//  os_gnt       out  1          OS beat accepted this cycle
//  dl_req       in   1          data-link beat available (TX buffer not empty)
//  dl_sop       in   1          beat is start of packet
//  dl_eop       in   1          beat is end of packet
//  dl_gnt       out  1          data beat accepted this cycle (buffer read enable)
//  skp_gnt      out  1          SKP OS emitted this cycle
//  tx_sel       out  2          mux select: 0 IDLE, 1 OS, 2 DATA, 3 SKP
//  skp_pending  out  1          SKP counter >= SKP_INTERVAL
//  skp_overdue  out  1          sticky; SKP deferred past INTERVAL+MAX_DEFER
//  pkt_abort    out  1          1-cycle pulse; packet cut by link_up drop
// BEHAVIOUR
//  Reset: state ARB_IDLE; all grants 0; tx_sel 0; skp counter 0; skp_pending 0; skp_overdue 0; pkt_abort 0.
//  Grants/tx_sel are registered: requests sampled in cycle N, grant in cycle N+1.
//  A beat transfers when req && gnt in the same cycle.
//  FSM states: ARB_IDLE, ARB_OS, ARB_DATA, ARB_SKP.
//  ARB_IDLE priority: skp_pending > os_req > (dl_req && dl_sop && link_up) > stay IDLE (tx_sel 0).
//  ARB_OS: os_gnt=1 while os_req; on os_req && os_last -> ARB_IDLE; os_req drop -> ARB_IDLE.
//  ARB_DATA: dl_gnt = dl_req; remain until dl_req && dl_eop -> ARB_IDLE. SKP never preempts.
//  ARB_DATA: no beat while dl_req=0 (bubble) -> stay, tx_sel 2, dl_gnt 0.
//  ARB_SKP: exactly 1 cycle, skp_gnt=1, counter cleared to 0 -> ARB_IDLE.
//  Counter: +1 every cycle outside ARB_SKP; saturates at all-ones; never wraps.
//  skp_overdue: sets when counter > SKP_INTERVAL+SKP_MAX_DEFER; cleared only by rst.
//  link_up 1->0 in ARB_DATA: next cycle -> ARB_IDLE, dl_gnt 0, pkt_abort pulses.
//  link_up 0: data never granted; OS and SKP unaffected.
//  dl_req without dl_sop in ARB_IDLE: ignored (no grant); protects against mid-packet start.
//  Simultaneous skp_pending and os_last completion: SKP follows OS immediately.
//  Reset mid-packet: all state dropped; no pkt_abort pulse on reset.
// CONFIGURATION
//  Macro PL_TX_SKP_SCHED_EN.
//  Defined: SKP counter, ARB_SKP state, skp_pending/skp_overdue active.
//  Undefined: no counter logic; skp_gnt, skp_pending, skp_overdue tied 0; ARB_SKP unreachable.
//  Undefined: priority reduces to os_req > data.
// STRUCTURE
//  Package pl_arb_pkg:
//   - enum arb_state_t {ARB_IDLE, ARB_OS, ARB_DATA, ARB_SKP}
//   - enum tx_sel_t {SEL_IDLE=0, SEL_OS=1, SEL_DATA=2, SEL_SKP=3}
//  Sub-module pl_skp_timer: counter, pending, overdue; inputs clr/hold.
//  pl_skp_timer is instantiated only under PL_TX_SKP_SCHED_EN.
// TESTING
//  1. Reset, then all requests 0 for 10 cycles -> tx_sel 0, no grants, counter 10.
//  2. os_req 4 beats, os_last on 4th -> os_gnt cycles 1-4 after req, then tx_sel 0.
//  3. Counter at 369, 8-beat TLP starts at 365 -> SKP granted cycle after eop; counter 0; skp_overdue 0.
//  4. Back-to-back TLPs spanning >498 cycles past last SKP -> skp_overdue=1, stays 1 until rst.
//  5. link_up drops on beat 3 of 6 -> next cycle ARB_IDLE, pkt_abort 1-cycle pulse, dl_gnt 0.
//  6. Build without PL_TX_SKP_SCHED_EN, 1000 idle cycles -> skp_gnt never 1; data/OS unchanged.

Source files
------------

// File: rtl/pl_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pl_arb_pkg
// Brief    : Shared state and mux-select encodings for the PL TX stream arbiter.
// Revision : 1.0
// ============================================================================
package pl_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OS   = 2'd1,
        ARB_DATA = 2'd2,
        ARB_SKP  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_OS   = 2'd1,
        SEL_DATA = 2'd2,
        SEL_SKP  = 2'd3
    } tx_sel_t;

    function automatic tx_sel_t state_to_sel(input arb_state_t s);
        tx_sel_t sel;
        case (s)
            ARB_OS:   sel = SEL_OS;
            ARB_DATA: sel = SEL_DATA;
            ARB_SKP:  sel = SEL_SKP;
            default:  sel = SEL_IDLE;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pl_skp_timer.sv
`default_nettype none
// ============================================================================
// Module   : pl_skp_timer
// Brief    : Saturating SKP spacing counter with pending and sticky overdue flags.
// Revision : 1.0
// ============================================================================
module pl_skp_timer #(
    parameter int unsigned SKP_INTERVAL  = 370,
    parameter int unsigned SKP_MAX_DEFER = 128,
    parameter int unsigned CNT_WIDTH     = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic pending,
    output logic overdue
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_THRESH = CNT_WIDTH'(SKP_INTERVAL);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT  = CNT_WIDTH'(SKP_INTERVAL + SKP_MAX_DEFER);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 overdue_q;
    logic                 overdue_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Looking at the next count lets overdue rise on the same edge the limit is crossed
        overdue_d = overdue_q | (cnt_d > CNT_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            overdue_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            overdue_q <= overdue_d;
        end
    end

    assign pending = (cnt_q >= CNT_THRESH);
    assign overdue = overdue_q;

endmodule
`default_nettype wire

// File: rtl/pl_tx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pl_tx_stream_arbiter
// Brief    : Schedules ordered sets, SKP insertion and DL packets onto the PL TX
//            path without splitting packets. SKP scheduling is built only when
//            PL_TX_SKP_SCHED_EN is defined.
// Revision : 1.0
// ============================================================================
module pl_tx_stream_arbiter
    import pl_arb_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL  = 370,
    parameter int unsigned SKP_MAX_DEFER = 128,
    parameter int unsigned CNT_WIDTH     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link_up,
    input  logic       os_req,
    input  logic       os_last,
    output logic       os_gnt,
    input  logic       dl_req,
    input  logic       dl_sop,
    input  logic       dl_eop,
    output logic       dl_gnt,
    output logic       skp_gnt,
    output logic [1:0] tx_sel,
    output logic       skp_pending,
    output logic       skp_overdue,
    output logic       pkt_abort
);

    arb_state_t state_q;
    arb_state_t state_d;
    arb_state_t done_next;
    tx_sel_t    tx_sel_q;
    tx_sel_t    tx_sel_d;
    logic       pkt_abort_q;
    logic       pkt_abort_d;

    logic       w_skp_pending;
    logic       w_skp_overdue;
    logic       w_skp_gnt;
    logic       w_in_skp;

    assign w_in_skp = (state_q == ARB_SKP);

`ifdef PL_TX_SKP_SCHED_EN
    // The arbiter never freezes the SKP clock, so hold stays low
    pl_skp_timer #(
        .SKP_INTERVAL  (SKP_INTERVAL),
        .SKP_MAX_DEFER (SKP_MAX_DEFER),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_skp_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_in_skp),
        .hold    (1'b0),
        .pending (w_skp_pending),
        .overdue (w_skp_overdue)
    );
    assign w_skp_gnt = w_in_skp;
`else
    logic unused_cfg;
    assign unused_cfg    = ^{SKP_INTERVAL, SKP_MAX_DEFER, CNT_WIDTH, w_in_skp};
    assign w_skp_pending = 1'b0;
    assign w_skp_overdue = 1'b0;
    assign w_skp_gnt     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pkt_abort_d = 1'b0;
        // A finishing OS or packet hands straight to a waiting SKP
        done_next   = w_skp_pending ? ARB_SKP : ARB_IDLE;

        case (state_q)
            ARB_IDLE: begin
                if (w_skp_pending) begin
                    state_d = ARB_SKP;
                end else if (os_req) begin
                    state_d = ARB_OS;
                end else if (dl_req && dl_sop && link_up) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_OS: begin
                if (!os_req) begin
                    state_d = ARB_IDLE;
                end else if (os_last) begin
                    state_d = done_next;
                end
            end
            ARB_DATA: begin
                if (!link_up) begin
                    state_d     = ARB_IDLE;
                    pkt_abort_d = 1'b1;
                end else if (dl_req && dl_eop) begin
                    state_d = done_next;
                end
            end
            ARB_SKP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        tx_sel_d = state_to_sel(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            tx_sel_q    <= SEL_IDLE;
            pkt_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_sel_q    <= tx_sel_d;
            pkt_abort_q <= pkt_abort_d;
        end
    end

    assign os_gnt      = (state_q == ARB_OS) && os_req;
    assign dl_gnt      = (state_q == ARB_DATA) && dl_req && link_up;
    assign skp_gnt     = w_skp_gnt;
    assign tx_sel      = tx_sel_q;
    assign skp_pending = w_skp_pending;
    assign skp_overdue = w_skp_overdue;
    assign pkt_abort   = pkt_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_pl_tx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pl_tx_stream_arbiter
// Brief    : Self-checking bench for pl_tx_stream_arbiter (vector table plus
//            multi-cycle sequences; SKP sequences when PL_TX_SKP_SCHED_EN).
// Revision : 1.0
// ============================================================================
module tb_pl_tx_stream_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       link_up, os_req, os_last, dl_req, dl_sop, dl_eop;
    logic       os_gnt, dl_gnt, skp_gnt, skp_pending, skp_overdue, pkt_abort;
    logic [1:0] tx_sel;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       lu, osr, osl, dr, ds, de;
        logic [1:0] sel;
        logic       og, dg, ab;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic       og, dg, ab;
    } exp_t;

    localparam int NV = 26;
    vec_t vecs[NV];
    exp_t exp_q[$];

    pl_tx_stream_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .link_up     (link_up),
        .os_req      (os_req),
        .os_last     (os_last),
        .os_gnt      (os_gnt),
        .dl_req      (dl_req),
        .dl_sop      (dl_sop),
        .dl_eop      (dl_eop),
        .dl_gnt      (dl_gnt),
        .skp_gnt     (skp_gnt),
        .tx_sel      (tx_sel),
        .skp_pending (skp_pending),
        .skp_overdue (skp_overdue),
        .pkt_abort   (pkt_abort)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic lu, osr, osl, dr, ds, de,
                                input logic [1:0] sel, input logic og, dg, ab);
        vec_t v;
        v.lu = lu; v.osr = osr; v.osl = osl; v.dr = dr; v.ds = ds; v.de = de;
        v.sel = sel; v.og = og; v.dg = dg; v.ab = ab;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic drive(input logic lu, osr, osl, dr, ds, de);
        link_up = lu; os_req = osr; os_last = osl;
        dl_req  = dr; dl_sop = ds;  dl_eop  = de;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic flag;

        // lu osr osl dr ds de | sel og dg ab
        vecs[0]  = mk(1,0,0,0,0,0, 2'd0,0,0,0);
        vecs[1]  = mk(1,1,0,0,0,0, 2'd0,0,0,0);
        vecs[2]  = mk(1,1,0,0,0,0, 2'd1,1,0,0);
        vecs[3]  = mk(1,1,0,0,0,0, 2'd1,1,0,0);
        vecs[4]  = mk(1,1,0,0,0,0, 2'd1,1,0,0);
        vecs[5]  = mk(1,1,1,0,0,0, 2'd1,1,0,0);
        vecs[6]  = mk(1,0,0,0,0,0, 2'd0,0,0,0);
        vecs[7]  = mk(1,0,0,1,0,0, 2'd0,0,0,0);
        vecs[8]  = mk(1,0,0,1,1,0, 2'd0,0,0,0);
        vecs[9]  = mk(1,0,0,1,1,0, 2'd2,0,1,0);
        vecs[10] = mk(1,0,0,1,0,0, 2'd2,0,1,0);
        vecs[11] = mk(1,0,0,0,0,0, 2'd2,0,0,0);
        vecs[12] = mk(1,0,0,1,0,1, 2'd2,0,1,0);
        vecs[13] = mk(1,0,0,0,0,0, 2'd0,0,0,0);
        vecs[14] = mk(1,1,0,1,1,0, 2'd0,0,0,0);
        vecs[15] = mk(1,1,1,1,1,0, 2'd1,1,0,0);
        vecs[16] = mk(1,0,0,1,1,0, 2'd0,0,0,0);
        vecs[17] = mk(1,0,0,1,1,0, 2'd2,0,1,0);
        vecs[18] = mk(1,0,0,1,0,0, 2'd2,0,1,0);
        vecs[19] = mk(0,0,0,1,0,0, 2'd2,0,0,0);
        vecs[20] = mk(0,0,0,1,1,0, 2'd0,0,0,1);
        vecs[21] = mk(0,1,0,1,1,0, 2'd0,0,0,0);
        vecs[22] = mk(0,1,1,0,0,0, 2'd1,1,0,0);
        vecs[23] = mk(1,1,0,0,0,0, 2'd0,0,0,0);
        vecs[24] = mk(1,0,0,0,0,0, 2'd1,0,0,0);
        vecs[25] = mk(1,0,0,0,0,0, 2'd0,0,0,0);

        // Reset state with requests active
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.tx_sel", tx_sel, 2'd0);
        chk("rst.os_gnt", os_gnt, 1'b0);
        chk("rst.dl_gnt", dl_gnt, 1'b0);
        chk("rst.skp_gnt", skp_gnt, 1'b0);
        chk("rst.skp_pending", skp_pending, 1'b0);
        chk("rst.skp_overdue", skp_overdue, 1'b0);
        chk("rst.pkt_abort", pkt_abort, 1'b0);

        do_reset();
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            drive(vecs[i].lu, vecs[i].osr, vecs[i].osl, vecs[i].dr, vecs[i].ds, vecs[i].de);
            exp_q.push_back('{sel: vecs[i].sel, og: vecs[i].og, dg: vecs[i].dg, ab: vecs[i].ab});
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("vec%0d.tx_sel", i), tx_sel, e.sel);
            chk($sformatf("vec%0d.os_gnt", i), os_gnt, e.og);
            chk($sformatf("vec%0d.dl_gnt", i), dl_gnt, e.dg);
            chk($sformatf("vec%0d.pkt_abort", i), pkt_abort, e.ab);
        end

        // Reset in the middle of a packet: no abort pulse, state dropped
        next_cycle(); drive(1, 0, 0, 1, 1, 0); @(negedge clk);
        chk("midrst.pre_sel", tx_sel, 2'd0);
        next_cycle(); drive(1, 0, 0, 1, 0, 0); @(negedge clk);
        chk("midrst.beat_sel", tx_sel, 2'd2);
        chk("midrst.beat_gnt", dl_gnt, 1'b1);
        next_cycle(); rst = 1'b1; drive(0, 0, 0, 1, 0, 0);
        next_cycle(); rst = 1'b0; drive(1, 0, 0, 1, 0, 0); @(negedge clk);
        chk("midrst.sel", tx_sel, 2'd0);
        chk("midrst.abort", pkt_abort, 1'b0);
        chk("midrst.dl_gnt", dl_gnt, 1'b0);
        next_cycle(); drive(1, 0, 0, 0, 0, 0); @(negedge clk);
        chk("midrst.abort2", pkt_abort, 1'b0);
        chk("midrst.nosop_sel", tx_sel, 2'd0);

`ifdef PL_TX_SKP_SCHED_EN
        // Idle from reset: pending at count 370, SKP granted one cycle later
        do_reset();
        flag = 1'b0;
        for (int c = 1; c <= 372; c++) begin
            next_cycle(); drive(1, 0, 0, 0, 0, 0); @(negedge clk);
            if (c < 371 && skp_gnt) flag = 1'b1;
            if (c == 10) begin
                chk("idle10.tx_sel", tx_sel, 2'd0);
                chk("idle10.grants", {os_gnt, dl_gnt, skp_gnt}, 3'b000);
            end
            if (c == 369) chk("idle.pending369", skp_pending, 1'b0);
            if (c == 370) chk("idle.pending370", skp_pending, 1'b1);
            if (c == 371) begin
                chk("idle.skp_gnt", skp_gnt, 1'b1);
                chk("idle.skp_sel", tx_sel, 2'd3);
            end
            if (c == 372) begin
                chk("idle.post_sel", tx_sel, 2'd0);
                chk("idle.post_pending", skp_pending, 1'b0);
            end
        end
        chk("idle.early_skp", flag, 1'b0);

        // 8-beat TLP straddling the threshold: SKP right after eop
        flag = 1'b0;
        for (int k = 1; k <= 374; k++) begin
            next_cycle();
            if (k == 364 || k == 365) drive(1, 0, 0, 1, 1, 0);
            else if (k > 365 && k < 372) drive(1, 0, 0, 1, 0, 0);
            else if (k == 372) drive(1, 0, 0, 1, 0, 1);
            else drive(1, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (k >= 365 && k <= 372 && !(dl_gnt && tx_sel == 2'd2)) flag = 1'b1;
            if (k == 370) chk("tlp.pending_no_preempt", {skp_pending, tx_sel}, 3'b110);
            if (k == 373) begin
                chk("tlp.skp_gnt", skp_gnt, 1'b1);
                chk("tlp.skp_sel", tx_sel, 2'd3);
                chk("tlp.overdue", skp_overdue, 1'b0);
            end
            if (k == 374) chk("tlp.cleared", {skp_pending, tx_sel}, 3'b000);
        end
        chk("tlp.beats", flag, 1'b0);

        // Long packet defers SKP past the limit: overdue sets at count 499 and sticks
        for (int j = 1; j <= 527; j++) begin
            next_cycle();
            if (j == 1) drive(1, 0, 0, 1, 1, 0);
            else if (j < 505) drive(1, 0, 0, 1, 0, 0);
            else if (j == 505) drive(1, 0, 0, 1, 0, 1);
            else drive(1, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (j == 2) chk("long.start", {tx_sel, dl_gnt}, 3'b101);
            if (j == 370) chk("long.no_preempt", tx_sel, 2'd2);
            if (j == 498) chk("long.overdue498", skp_overdue, 1'b0);
            if (j == 499) chk("long.overdue499", skp_overdue, 1'b1);
            if (j == 506) chk("long.skp_sel", {skp_gnt, tx_sel}, 3'b111);
            if (j == 527) chk("long.sticky", skp_overdue, 1'b1);
        end
        do_reset();
        @(negedge clk);
        chk("long.rst_clears", skp_overdue, 1'b0);
`else
        // Without SKP scheduling nothing SKP-related ever asserts
        do_reset();
        flag = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            next_cycle(); drive(1, 0, 0, 0, 0, 0); @(negedge clk);
            if (skp_gnt || skp_pending || skp_overdue || tx_sel != 2'd0) flag = 1'b1;
        end
        chk("noskp.idle1000", flag, 1'b0);
        next_cycle(); drive(1, 1, 1, 0, 0, 0); @(negedge clk);
        chk("noskp.os_req_sel", tx_sel, 2'd0);
        next_cycle(); drive(1, 1, 1, 0, 0, 0); @(negedge clk);
        chk("noskp.os_gnt", {os_gnt, tx_sel}, 3'b101);
        next_cycle(); drive(1, 0, 0, 0, 0, 0); @(negedge clk);
        chk("noskp.os_done", {os_gnt, tx_sel, skp_gnt}, 4'b0000);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
